// File: rtl/fifo_arb_pkg.sv
// Shared defaults, index/credit types and a width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned DEPTH_DEF     = 8;
    localparam int unsigned WIDTH_DEF     = 8;
    localparam int unsigned MAX_BURST_DEF = 2;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(N_REQ_DEF)-1:0]     req_idx_t;
    typedef logic [$clog2(DEPTH_DEF + 1)-1:0]    credit_t;
    typedef logic [idx_width(MAX_BURST_DEF)-1:0] burst_cnt_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer request bus plus FIFO write-side signals seen by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*WIDTH-1:0]      req_data;
    logic [N_REQ-1:0]            gnt;
    logic                        fifo_w_en;
    logic [WIDTH-1:0]            fifo_data_in;
    logic                        fifo_r_en;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [$clog2(DEPTH+1)-1:0]  credits;

    // Arbiter side.
    modport master (
        input  req, req_data, fifo_r_en, fifo_empty, fifo_full,
        output gnt, fifo_w_en, fifo_data_in, credits
    );

    // Producers and FIFO side.
    modport slave (
        output req, req_data, fifo_r_en, fifo_empty, fifo_full,
        input  gnt, fifo_w_en, fifo_data_in, credits
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin find-first-set: first requester at or after ptr+1, wrapping.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] cand;

    // Walk N positions starting just past the pointer; keep the first hit.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port between N_REQ producers.
// A shadow credit count (free slots minus claimed ones) keeps writes out of a full FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.master arb_io
);

    localparam int unsigned IdxW     = idx_width(N_REQ);
    localparam int unsigned CredW    = $clog2(DEPTH + 1);
    localparam int unsigned BurstW   = idx_width(MAX_BURST);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST - 1);
    localparam logic [CredW-1:0]  CredMax  = CredW'(DEPTH);

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic              owner_vld_q, owner_vld_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [CredW-1:0]  credits_q, credits_d;
    logic              w_en_q, w_en_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   win_idx;
    logic              others_req;
    logic              keep_owner;
    logic              grant;
    logic              rd_valid;

    rr_pick #(
        .N    (N_REQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (arb_io.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    // Winner selection and combinational grant; reset and zero credit both block grants.
    always_comb begin
        others_req = |(arb_io.req & ~(N_REQ'(1) << owner_q));
        keep_owner = owner_vld_q && arb_io.req[owner_q] &&
                     ((burst_q < BurstMax) || !others_req);
        win_idx    = keep_owner ? owner_q : pick_idx;
        grant      = !rst && (credits_q != '0) && (keep_owner || pick_vld);
        arb_io.gnt = grant ? (N_REQ'(1) << win_idx) : '0;
    end

    // Next state: credits, owner/burst tracking, write register.
    always_comb begin
        rd_valid    = arb_io.fifo_r_en && !arb_io.fifo_empty;
        credits_d   = credits_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_d     = burst_q;
        w_en_d      = grant;
        data_d      = data_q;

        if (grant && !rd_valid) begin
            credits_d = credits_q - CredW'(1);
        end else if (rd_valid && !grant && (credits_q != CredMax)) begin
            credits_d = credits_q + CredW'(1);
        end

        if (grant) begin
            data_d = arb_io.req_data[32'(win_idx) * WIDTH +: WIDTH];
            if (keep_owner) begin
                // Saturate: once at the limit the owner only continues while alone.
                if (burst_q < BurstMax) begin
                    burst_d = burst_q + BurstW'(1);
                end
            end else begin
                ptr_d       = pick_idx;
                owner_d     = pick_idx;
                owner_vld_d = 1'b1;
                burst_d     = '0;
            end
        end
    end

    // State registers; reset drops any pending write and restores full credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= IdxW'(N_REQ - 1);
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_q     <= '0;
            credits_q   <= CredMax;
            w_en_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_q     <= burst_d;
            credits_q   <= credits_d;
            w_en_q      <= w_en_d;
            data_q      <= data_d;
        end
    end

    assign arb_io.fifo_w_en    = w_en_q;
    assign arb_io.fifo_data_in = data_q;
    assign arb_io.credits      = credits_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(arb_io.gnt));
    a_no_full_write: assert property (@(posedge clk) disable iff (rst)
        !(arb_io.fifo_w_en && arb_io.fifo_full));
    a_credit_max: assert property (@(posedge clk) disable iff (rst)
        (arb_io.fifo_r_en && !arb_io.fifo_empty) |-> (credits_q < CredMax));

    for (genvar i = 0; i < N_REQ; i++) begin : g_req_chk
        a_gnt_has_req: assert property (@(posedge clk) disable iff (rst)
            arb_io.gnt[i] |-> arb_io.req[i]);
        // A requester must hold req until it is granted.
        a_req_held: assert property (@(posedge clk)
            (!rst && arb_io.req[i] && !arb_io.gnt[i]) |=> (rst || arb_io.req[i]));
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: dut_a (MAX_BURST=2) with a FIFO occupancy model, dut_b (MAX_BURST=1).
module tb_fifo_wr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DEPTH(D), .WIDTH(W)) ia ();
    fifo_wr_arbiter_if #(.N_REQ(N), .DEPTH(D), .WIDTH(W)) ib ();

    fifo_wr_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W), .MAX_BURST(2)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .arb_io (ia)
    );

    fifo_wr_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W), .MAX_BURST(1)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .arb_io (ib)
    );

    // FIFO occupancy model for dut_a; wr_log records every accepted write in order.
    int         fcnt = 0;
    logic [W-1:0] wr_log[$];
    always @(posedge clk) begin
        if (rst) begin
            fcnt <= 0;
            wr_log.delete();
        end else begin
            fcnt <= fcnt + (ia.fifo_w_en ? 1 : 0) - ((ia.fifo_r_en && fcnt != 0) ? 1 : 0);
            if (ia.fifo_w_en) wr_log.push_back(ia.fifo_data_in);
        end
    end
    assign ia.fifo_empty = (fcnt == 0);
    assign ia.fifo_full  = (fcnt >= int'(D));
    assign ib.fifo_empty = 1'b1;
    assign ib.fifo_full  = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ia.req = '0; ia.fifo_r_en = 1'b0;
        ib.req = '0; ib.fifo_r_en = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ia.req = 4'b1111; ia.req_data = 32'hA3A2A1A0; ia.fifo_r_en = 1'b0;
        ib.req = 4'b0000; ib.req_data = '0;           ib.fifo_r_en = 1'b0;
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000) begin
            n_err++; $display("FAIL rst_gnt_in_reset: got %b want 0000", ia.gnt);
        end
        cyc();
        n_vec++;
        if ({ia.fifo_w_en, ia.fifo_data_in} !== 9'h000) begin
            n_err++; $display("FAIL rst_wr: got w_en=%b data=%h want 0/00",
                              ia.fifo_w_en, ia.fifo_data_in);
        end
        n_vec++;
        if (ia.credits !== 4'd8) begin
            n_err++; $display("FAIL rst_credits_a: got %0d want 8", ia.credits);
        end
        n_vec++;
        if (ib.credits !== 4'd8) begin
            n_err++; $display("FAIL rst_credits_b: got %0d want 8", ib.credits);
        end
        ia.req = '0;
        cyc();
        rst = 1'b0;
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000) begin
            n_err++; $display("FAIL rst_gnt_idle: got %b want 0000", ia.gnt);
        end
    endtask

    // Single requester, no reads: eight grants, then credit exhaustion; then one read frees one slot.
    task automatic test_fill_and_full();
        ia.req = 4'b0001; ia.req_data = 32'h000000A0; ia.fifo_r_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_vec++;
            if (ia.gnt !== 4'b0001 || ia.credits !== 4'(8 - k)) begin
                n_err++; $display("FAIL fill[%0d]: got gnt=%b credits=%0d want 0001/%0d",
                                  k, ia.gnt, ia.credits, 8 - k);
            end
            cyc();
        end
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000 || ia.credits !== 4'd0) begin
            n_err++; $display("FAIL full_stop: got gnt=%b credits=%0d want 0000/0",
                              ia.gnt, ia.credits);
        end
        n_vec++;
        if ({ia.fifo_w_en, ia.fifo_data_in} !== 9'h1A0) begin
            n_err++; $display("FAIL full_last_wr: got w_en=%b data=%h want 1/a0",
                              ia.fifo_w_en, ia.fifo_data_in);
        end
        cyc();
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000 || ia.fifo_w_en !== 1'b0) begin
            n_err++; $display("FAIL full_hold: got gnt=%b w_en=%b want 0000/0",
                              ia.gnt, ia.fifo_w_en);
        end
        // Read in this cycle; grant may only follow next cycle.
        ia.fifo_r_en = 1'b1;
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000) begin
            n_err++; $display("FAIL full_read_same_cycle: got gnt=%b want 0000", ia.gnt);
        end
        cyc();
        ia.fifo_r_en = 1'b0;
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0001 || ia.credits !== 4'd1) begin
            n_err++; $display("FAIL full_after_read: got gnt=%b credits=%0d want 0001/1",
                              ia.gnt, ia.credits);
        end
        cyc();
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000 || ia.credits !== 4'd0 || ia.fifo_w_en !== 1'b1) begin
            n_err++; $display("FAIL full_refill: got gnt=%b credits=%0d w_en=%b want 0000/0/1",
                              ia.gnt, ia.credits, ia.fifo_w_en);
        end
        do_reset();
    endtask

    // All four requesting, FIFO drained each cycle, bursts of two.
    task automatic test_round_robin_burst();
        int         exp_idx[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [3:0] exp_gnt;
        logic [7:0] exp_dat;
        ia.req = 4'b1111; ia.req_data = 32'hA3A2A1A0; ia.fifo_r_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_gnt = 4'b0001 << exp_idx[k];
            n_vec++;
            if (ia.gnt !== exp_gnt) begin
                n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, ia.gnt, exp_gnt);
            end
            if (k > 0) begin
                exp_dat = 8'hA0 + 8'(exp_idx[k-1]);
                n_vec++;
                if (ia.fifo_w_en !== 1'b1 || ia.fifo_data_in !== exp_dat) begin
                    n_err++; $display("FAIL rr_data[%0d]: got w_en=%b data=%h want 1/%h",
                                      k, ia.fifo_w_en, ia.fifo_data_in, exp_dat);
                end
            end
            cyc();
        end
        do_reset();
    endtask

    // MAX_BURST=1 with requesters 0 and 2: strict alternation, data one cycle later.
    task automatic test_alternate();
        int         exp_idx[4] = '{0, 2, 0, 2};
        logic [7:0] dat[4]     = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] exp_gnt;
        ib.req = 4'b0101; ib.req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k < 4) begin
                exp_gnt = 4'b0001 << exp_idx[k];
                n_vec++;
                if (ib.gnt !== exp_gnt) begin
                    n_err++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, ib.gnt, exp_gnt);
                end
            end
            if (k > 0) begin
                n_vec++;
                if (ib.fifo_w_en !== 1'b1 || ib.fifo_data_in !== dat[exp_idx[k-1]]) begin
                    n_err++; $display("FAIL alt_data[%0d]: got w_en=%b data=%h want 1/%h",
                                      k, ib.fifo_w_en, ib.fifo_data_in, dat[exp_idx[k-1]]);
                end
            end
            cyc();
        end
        do_reset();
    endtask

    // At one credit, a grant and a read in the same cycle leave the count at one.
    task automatic test_last_credit_read();
        for (int k = 0; k < 8; k++) begin
            ia.req = 4'b0001; ia.req_data = 32'(8'h50 + 8'(k));
            ia.fifo_r_en = (k == 7);
            #1;
            n_vec++;
            if (ia.gnt !== 4'b0001 || ia.credits !== 4'(8 - k)) begin
                n_err++; $display("FAIL lc_fill[%0d]: got gnt=%b credits=%0d want 0001/%0d",
                                  k, ia.gnt, ia.credits, 8 - k);
            end
            cyc();
        end
        ia.req = 4'b0000; ia.fifo_r_en = 1'b0;
        #1;
        n_vec++;
        if (ia.credits !== 4'd1 || ia.gnt !== 4'b0000) begin
            n_err++; $display("FAIL lc_credit_kept: got credits=%0d gnt=%b want 1/0000",
                              ia.credits, ia.gnt);
        end
        n_vec++;
        if (ia.fifo_w_en !== 1'b1 || ia.fifo_data_in !== 8'h57) begin
            n_err++; $display("FAIL lc_last_wr: got w_en=%b data=%h want 1/57",
                              ia.fifo_w_en, ia.fifo_data_in);
        end
        cyc();
        #1;
        n_vec++;
        if (wr_log.size() != 8) begin
            n_err++; $display("FAIL lc_log_size: got %0d want 8", wr_log.size());
        end
        for (int i = 0; i < wr_log.size(); i++) begin
            n_vec++;
            if (wr_log[i] !== 8'h50 + 8'(i)) begin
                n_err++; $display("FAIL lc_order[%0d]: got %h want %h", i, wr_log[i], 8'h50 + 8'(i));
            end
        end
        do_reset();
    endtask

    // Reset while a registered write is pending: the write is dropped, arbitration restarts.
    task automatic test_reset_mid_burst();
        ia.req = 4'b1111; ia.req_data = 32'hA3A2A1A0; ia.fifo_r_en = 1'b0;
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0001) begin
            n_err++; $display("FAIL mid_gnt0: got %b want 0001", ia.gnt);
        end
        cyc();
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0001 || ia.fifo_w_en !== 1'b1) begin
            n_err++; $display("FAIL mid_gnt1: got gnt=%b w_en=%b want 0001/1", ia.gnt, ia.fifo_w_en);
        end
        cyc();
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0010 || ia.fifo_w_en !== 1'b1 || ia.fifo_data_in !== 8'hA0) begin
            n_err++; $display("FAIL mid_pending: got gnt=%b w_en=%b data=%h want 0010/1/a0",
                              ia.gnt, ia.fifo_w_en, ia.fifo_data_in);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (ia.gnt !== 4'b0000) begin
            n_err++; $display("FAIL mid_rst_gnt: got %b want 0000", ia.gnt);
        end
        cyc();
        rst = 1'b0;
        #1;
        n_vec++;
        if (ia.fifo_w_en !== 1'b0 || ia.credits !== 4'd8) begin
            n_err++; $display("FAIL mid_after_rst: got w_en=%b credits=%0d want 0/8",
                              ia.fifo_w_en, ia.credits);
        end
        n_vec++;
        if (ia.gnt !== 4'b0001) begin
            n_err++; $display("FAIL mid_restart_gnt: got %b want 0001", ia.gnt);
        end
        cyc();
        #1;
        n_vec++;
        if (ia.fifo_w_en !== 1'b1 || ia.fifo_data_in !== 8'hA0) begin
            n_err++; $display("FAIL mid_restart_wr: got w_en=%b data=%h want 1/a0",
                              ia.fifo_w_en, ia.fifo_data_in);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fill_and_full();
        test_round_robin_burst();
        test_alternate();
        test_last_credit_read();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
